regfile_sb: RTL and testbench

Parametrised multi-port integer register file for the LemonPC core with write-port conflict resolution, optional same-cycle write-to-read bypass, a per-register busy scoreboard for hazard detection, and a bounded change-log FIFO that replaces ad-hoc simulation prints with a drainable debug stream. It sits between decode (reads, issue) and writeback (writes), and exports the log to the difftest/trace logic.

---
 rtl/lemon_rf_pkg.sv | 15 +
 rtl/rf_log_fifo.sv | 78 +++++++
 rtl/regfile_sb.sv | 146 ++++++++++++++
 tb/tb_regfile_sb.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lemon_rf_pkg.sv
// Shared types and constants for the LemonPC integer register file.
package lemon_rf_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 64;
    localparam int RF_ZERO_IDX = 0;

    // One change-log record at the default register-file geometry.
    typedef struct packed {
        logic [RF_ADDR_W-1:0] idx;
        logic [RF_DATA_W-1:0] old_val;
        logic [RF_DATA_W-1:0] new_val;
    } rf_log_entry_t;

endpackage

// File: rtl/rf_log_fifo.sv
// Change-log FIFO: up to NPUSH pushes per cycle in port order, one pop,
// pushes beyond capacity are dropped and latch a sticky overflow flag.
module rf_log_fifo
    import lemon_rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int NPUSH = 2,
    parameter int WIDTH = RF_ADDR_W + 2*RF_DATA_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NPUSH-1:0]       push_valid_i,
    input  logic [NPUSH*WIDTH-1:0] push_data_i,
    input  logic                   pop_ready_i,
    output logic                   head_valid_o,
    output logic [WIDTH-1:0]       head_data_o,
    output logic                   ovf_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             pop;

    assign pop          = (count_q != '0) && pop_ready_i;
    assign head_valid_o = (count_q != '0);
    // Head data is forced to zero when empty so reset leaves a clean head.
    assign head_data_o  = head_valid_o ? mem_q[rd_ptr_q] : '0;
    assign ovf_o        = ovf_q;

    // Pop first so its slot is available to the pushes of the same cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q - CW'(pop);
        ovf_d    = ovf_q;
        for (int j = 0; j < NPUSH; j++) begin
            if (push_valid_i[j]) begin
                if (count_d < FULL_CNT) begin
                    mem_d[wr_ptr_d] = push_data_i[j*WIDTH +: WIDTH];
                    wr_ptr_d        = wr_ptr_d + PW'(1);
                    count_d         = count_d + CW'(1);
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    // Pointer, occupancy and overflow state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Entry storage; contents are only observed through a valid head.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with write arbitration, optional
// write-to-read bypass, busy scoreboard and a drainable change log.
module regfile_sb
    import lemon_rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_W,
    parameter int DATA_WIDTH = RF_DATA_W,
    parameter int NREAD      = 2,
    parameter int NWRITE     = 2,
    parameter int BYPASS     = 1,
    parameter int LOG_DEPTH  = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NREAD*ADDR_WIDTH-1:0]  rs_addr_i,
    output logic [NREAD*DATA_WIDTH-1:0]  rs_data_o,
    output logic [NREAD-1:0]             rs_busy_o,
    input  logic [NWRITE-1:0]            wen_i,
    input  logic [NWRITE*ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [NWRITE*DATA_WIDTH-1:0] wr_data_i,
    input  logic                         iss_valid_i,
    input  logic [ADDR_WIDTH-1:0]        iss_rd_i,
    output logic                         log_valid_o,
    input  logic                         log_ready_i,
    output logic [ADDR_WIDTH-1:0]        log_idx_o,
    output logic [DATA_WIDTH-1:0]        log_old_o,
    output logic [DATA_WIDTH-1:0]        log_new_o,
    output logic                         log_ovf_o
);

    localparam int NREG    = 1 << ADDR_WIDTH;
    localparam int ENTRY_W = ADDR_WIDTH + 2*DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(RF_ZERO_IDX);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] idx;
        logic [DATA_WIDTH-1:0] old_val;
        logic [DATA_WIDTH-1:0] new_val;
    } log_entry_t;

    logic [DATA_WIDTH-1:0] regs_q [NREG];
    logic [DATA_WIDTH-1:0] regs_d [NREG];
    logic [NREG-1:0]       busy_q, busy_d;

    logic [ADDR_WIDTH-1:0] wa [NWRITE];
    logic [DATA_WIDTH-1:0] wd [NWRITE];
    logic [ADDR_WIDTH-1:0] ra [NREAD];
    logic [NWRITE-1:0]     commit;

    logic [NWRITE-1:0]         push_valid;
    logic [NWRITE*ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0]        head_data;
    log_entry_t                head;

    for (genvar g = 0; g < NWRITE; g++) begin : g_wr_unpack
        assign wa[g] = wr_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wd[g] = wr_data_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_rd_unpack
        assign ra[g] = rs_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // A port commits unless it targets x0 or a higher port writes the same index.
    always_comb begin
        commit = '0;
        for (int j = 0; j < NWRITE; j++) begin
            commit[j] = wen_i[j] && (wa[j] != ZERO_IDX);
            for (int k = j + 1; k < NWRITE; k++) begin
                if (wen_i[k] && (wa[k] == wa[j])) begin
                    commit[j] = 1'b0;
                end
            end
        end
    end

    // Next array/busy state and log pushes; issue is applied last so it beats a clear.
    always_comb begin
        regs_d     = regs_q;
        busy_d     = busy_q;
        push_valid = '0;
        push_data  = '0;
        for (int j = 0; j < NWRITE; j++) begin
            if (commit[j]) begin
                regs_d[wa[j]] = wd[j];
                busy_d[wa[j]] = 1'b0;
                push_valid[j] = (wd[j] != regs_q[wa[j]]);
                push_data[j*ENTRY_W +: ENTRY_W] = {wa[j], regs_q[wa[j]], wd[j]};
            end
        end
        if (iss_valid_i && (iss_rd_i != ZERO_IDX)) begin
            busy_d[iss_rd_i] = 1'b1;
        end
    end

    // Register array and scoreboard.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read ports; winners are unique per index so at most one bypass source matches.
    always_comb begin
        rs_data_o = '0;
        rs_busy_o = '0;
        for (int k = 0; k < NREAD; k++) begin
            rs_data_o[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[ra[k]];
            if (BYPASS != 0) begin
                for (int j = 0; j < NWRITE; j++) begin
                    if (commit[j] && (wa[j] == ra[k])) begin
                        rs_data_o[k*DATA_WIDTH +: DATA_WIDTH] = wd[j];
                    end
                end
            end
            rs_busy_o[k] = busy_q[ra[k]];
        end
    end

    rf_log_fifo #(
        .DEPTH (LOG_DEPTH),
        .NPUSH (NWRITE),
        .WIDTH (ENTRY_W)
    ) u_log_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_valid_i (push_valid),
        .push_data_i  (push_data),
        .pop_ready_i  (log_ready_i),
        .head_valid_o (log_valid_o),
        .head_data_o  (head_data),
        .ovf_o        (log_ovf_o)
    );

    assign head      = head_data;
    assign log_idx_o = head.idx;
    assign log_old_o = head.old_val;
    assign log_new_o = head.new_val;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb at default geometry (32x64, 2R/2W, bypass, 4-entry log).
module tb_regfile_sb;

    localparam int AW = 5;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [2*AW-1:0] rs_addr = '0;
    logic [2*DW-1:0] rs_data;
    logic [1:0]      rs_busy;
    logic [1:0]      wen = '0;
    logic [2*AW-1:0] wr_addr = '0;
    logic [2*DW-1:0] wr_data = '0;
    logic            iss_valid = 1'b0;
    logic [AW-1:0]   iss_rd = '0;
    logic            log_valid;
    logic            log_ready = 1'b0;
    logic [AW-1:0]   log_idx;
    logic [DW-1:0]   log_old;
    logic [DW-1:0]   log_new;
    logic            log_ovf;

    int n_chk = 0;
    int n_err = 0;

    regfile_sb #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NREAD      (2),
        .NWRITE     (2),
        .BYPASS     (1),
        .LOG_DEPTH  (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rs_addr_i   (rs_addr),
        .rs_data_o   (rs_data),
        .rs_busy_o   (rs_busy),
        .wen_i       (wen),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .iss_valid_i (iss_valid),
        .iss_rd_i    (iss_rd),
        .log_valid_o (log_valid),
        .log_ready_i (log_ready),
        .log_idx_o   (log_idx),
        .log_old_o   (log_old),
        .log_new_o   (log_new),
        .log_ovf_o   (log_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wen[p] = 1'b1;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic clr_wr();
        wen = '0;
        wr_addr = '0;
        wr_data = '0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rs_addr[p*AW +: AW] = a;
    endtask

    function automatic logic [63:0] rd(input int p);
        return rs_data[p*DW +: DW];
    endfunction

    task automatic pop1();
        log_ready = 1'b1;
        tick();
        log_ready = 1'b0;
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [AW-1:0] i,
                            input logic [DW-1:0] o, input logic [DW-1:0] n);
        chk({tag, ".valid"}, 64'(log_valid), 64'd1);
        chk({tag, ".idx"},   64'(log_idx),   64'(i));
        chk({tag, ".old"},   log_old,        o);
        chk({tag, ".new"},   log_new,        n);
    endtask

    initial begin
        // Writes, issue and pop during reset must all be overridden.
        set_wr(0, 5'd9, 64'h55);
        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        log_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        clr_wr();
        iss_valid = 1'b0;
        log_ready = 1'b0;
        set_rd(0, 5'd9);
        #1;
        chk("rst_x9", rd(0), 64'h0);
        chk("rst_busy9", 64'(rs_busy[0]), 64'd0);
        chk("rst_logv", 64'(log_valid), 64'd0);
        chk("rst_ovf", 64'(log_ovf), 64'd0);
        chk("rst_logidx", 64'(log_idx), 64'd0);
        for (int r = 0; r < 32; r++) begin
            set_rd(0, 5'(r));
            set_rd(1, 5'(31 - r));
            #1;
            chk("rst_rd0", rd(0), 64'h0);
            chk("rst_rd1", rd(1), 64'h0);
            chk("rst_busy", 64'(rs_busy), 64'd0);
        end

        // Bypass and first log entry.
        set_wr(0, 5'd5, 64'h1234);
        set_rd(0, 5'd5);
        #1;
        chk("byp_x5", rd(0), 64'h1234);
        chk("byp_logv", 64'(log_valid), 64'd0);
        tick();
        clr_wr();
        #1;
        chk("x5_stored", rd(0), 64'h1234);
        chk_head("log_x5", 5'd5, 64'h0, 64'h1234);
        set_wr(0, 5'd5, 64'h1234);
        tick();
        clr_wr();
        pop1();
        chk("same_val_nolog", 64'(log_valid), 64'd0);

        // Same-index conflict: port 1 wins, single entry.
        set_wr(0, 5'd7, 64'hAA);
        set_wr(1, 5'd7, 64'hBB);
        set_rd(1, 5'd7);
        #1;
        chk("byp_conflict", rd(1), 64'hBB);
        tick();
        clr_wr();
        #1;
        chk("x7_win", rd(1), 64'hBB);
        chk_head("log_x7", 5'd7, 64'h0, 64'hBB);
        pop1();
        chk("x7_one_entry", 64'(log_valid), 64'd0);
        set_wr(0, 5'd7, 64'hCC);
        tick();
        clr_wr();
        #1;
        chk_head("log_x7_old", 5'd7, 64'hBB, 64'hCC);
        pop1();
        set_wr(1, 5'd0, 64'hFF);
        set_rd(0, 5'd0);
        #1;
        chk("x0_byp", rd(0), 64'h0);
        tick();
        clr_wr();
        #1;
        chk("x0_read", rd(0), 64'h0);
        chk("x0_nolog", 64'(log_valid), 64'd0);

        // Scoreboard.
        iss_valid = 1'b1;
        iss_rd    = 5'd3;
        set_rd(0, 5'd3);
        #1;
        chk("busy_not_byp", 64'(rs_busy[0]), 64'd0);
        tick();
        iss_valid = 1'b0;
        #1;
        chk("busy_set", 64'(rs_busy[0]), 64'd1);
        set_wr(0, 5'd3, 64'h33);
        iss_valid = 1'b1;
        tick();
        clr_wr();
        iss_valid = 1'b0;
        #1;
        chk("busy_set_wins", 64'(rs_busy[0]), 64'd1);
        chk_head("log_x3", 5'd3, 64'h0, 64'h33);
        set_wr(0, 5'd3, 64'h33);
        tick();
        clr_wr();
        #1;
        chk("busy_clr", 64'(rs_busy[0]), 64'd0);
        pop1();
        chk("x3_nolog", 64'(log_valid), 64'd0);

        // Five changes into a 4-entry log.
        for (int i = 0; i < 5; i++) begin
            set_wr(0, 5'(10 + i), 64'(32'h100 + i));
            tick();
            clr_wr();
            #1;
            if (i == 3) chk("ovf_at_full", 64'(log_ovf), 64'd0);
        end
        chk("ovf_set", 64'(log_ovf), 64'd1);
        set_rd(0, 5'd14);
        #1;
        chk("x14_written", rd(0), 64'h104);
        for (int i = 0; i < 4; i++) begin
            chk_head("drain", 5'(10 + i), 64'h0, 64'(32'h100 + i));
            pop1();
        end
        chk("drain_empty", 64'(log_valid), 64'd0);
        chk("drain_idx0", 64'(log_idx), 64'd0);
        chk("ovf_sticky", 64'(log_ovf), 64'd1);

        // Reset clears overflow, then pop-plus-two-pushes on a full log.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_rd(0, 5'd10);
        #1;
        chk("rst2_ovf", 64'(log_ovf), 64'd0);
        chk("rst2_logv", 64'(log_valid), 64'd0);
        chk("rst2_x10", rd(0), 64'h0);
        set_wr(0, 5'd1, 64'hA1);
        set_wr(1, 5'd2, 64'hA2);
        tick();
        set_wr(0, 5'd3, 64'hA3);
        set_wr(1, 5'd4, 64'hA4);
        tick();
        clr_wr();
        #1;
        chk("full_noovf", 64'(log_ovf), 64'd0);
        chk_head("full_head", 5'd1, 64'h0, 64'hA1);
        log_ready = 1'b1;
        set_wr(0, 5'd5, 64'hC5);
        set_wr(1, 5'd6, 64'hC6);
        tick();
        clr_wr();
        log_ready = 1'b0;
        #1;
        chk("pp_ovf", 64'(log_ovf), 64'd1);
        chk_head("pp_head", 5'd2, 64'h0, 64'hA2);
        set_rd(0, 5'd6);
        #1;
        chk("x6_written", rd(0), 64'hC6);
        pop1();
        chk_head("pp_x3", 5'd3, 64'h0, 64'hA3);
        pop1();
        chk_head("pp_x4", 5'd4, 64'h0, 64'hA4);
        pop1();
        chk_head("pp_x5", 5'd5, 64'h0, 64'hC5);
        rst = 1'b1;
        log_ready = 1'b1;
        tick();
        rst = 1'b0;
        log_ready = 1'b0;
        #1;
        chk("mid_rst_logv", 64'(log_valid), 64'd0);
        chk("mid_rst_ovf", 64'(log_ovf), 64'd0);
        chk("mid_rst_idx", 64'(log_idx), 64'd0);
        chk("mid_rst_old", log_old, 64'h0);
        chk("mid_rst_new", log_new, 64'h0);
        chk("mid_rst_x6", rd(0), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
